// File: rtl/video_pkg.sv
// Shared TMDS constants, stage bundle and symbol helpers for the DVI encoder.
package video_pkg;

  localparam int TMDS_SYM_W = 10;

  localparam logic [TMDS_SYM_W-1:0] CTRL_00 = 10'h354;
  localparam logic [TMDS_SYM_W-1:0] CTRL_01 = 10'h0AB;
  localparam logic [TMDS_SYM_W-1:0] CTRL_10 = 10'h154;
  localparam logic [TMDS_SYM_W-1:0] CTRL_11 = 10'h2AB;

  typedef struct packed {
    logic       de;
    logic [1:0] ctrl;
    logic [8:0] qm;
    logic [3:0] n1;
  } tmds_s1_t;

  function automatic logic [TMDS_SYM_W-1:0] ctrl_code(
    input logic [1:0] c
  );
    logic [TMDS_SYM_W-1:0] s;
    unique case (c)
      2'b00:   s = CTRL_00;
      2'b01:   s = CTRL_01;
      2'b10:   s = CTRL_10;
      default: s = CTRL_11;
    endcase
    return s;
  endfunction

  function automatic logic [3:0] ones8(
    input logic [7:0] d
  );
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, d[i]};
    end
    return n;
  endfunction

  // Transition-minimising stage; bit 8 flags the XOR chain.
  function automatic logic [8:0] tmds_qm(
    input logic [7:0] d
  );
    logic [3:0] n;
    logic       x;
    logic [8:0] q;
    n    = ones8(d);
    x    = (n > 4'd4) || ((n == 4'd4) && !d[0]);
    q    = '0;
    q[0] = d[0];
    for (int i = 1; i < 8; i++) begin
      q[i] = x ? ~(q[i-1] ^ d[i]) : (q[i-1] ^ d[i]);
    end
    q[8] = ~x;
    return q;
  endfunction

endpackage

// File: rtl/tmds_channel_enc.sv
// One TMDS channel: q_m stage, then symbol select with running disparity.
// TMDS_DISPARITY_MON_EN exposes the disparity counter on cnt_o.
module tmds_channel_enc
  import video_pkg::*;
#(
  parameter int         CNT_W      = 5,
  parameter logic [1:0] RESET_CTRL = 2'b00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            d_i,
  input  logic                  de_i,
  input  logic [1:0]            ctrl_i,
  output logic [TMDS_SYM_W-1:0] sym_o
`ifdef TMDS_DISPARITY_MON_EN
  ,
  output logic signed [CNT_W-1:0] cnt_o
`endif
);

  localparam logic signed [CNT_W-1:0] TWO  = CNT_W'(2);
  localparam logic signed [CNT_W-1:0] ZERO = '0;
  localparam logic signed [CNT_W-1:0] EIGHT = CNT_W'(8);

  tmds_s1_t s1_d, s1_q;

  logic [TMDS_SYM_W-1:0] sym_d, sym_q;
  logic signed [CNT_W-1:0] cnt_d, cnt_q;
  logic signed [CNT_W-1:0] diff;
  logic [8:0] qm_w;
  logic [7:0] qm;
  logic       qm8;
  logic       pos, neg;

  assign qm_w = tmds_qm(d_i);

  always_comb begin
    s1_d.de   = de_i;
    s1_d.ctrl = ctrl_i;
    s1_d.qm   = qm_w;
    s1_d.n1   = ones8(qm_w[7:0]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_q <= '0;
    end else begin
      s1_q <= s1_d;
    end
  end

  assign qm   = s1_q.qm[7:0];
  assign qm8  = s1_q.qm[8];
  // N1 - N0 == 2*N1 - 8
  assign diff = CNT_W'({s1_q.n1, 1'b0}) - EIGHT;
  assign pos  = !cnt_q[CNT_W-1] && (cnt_q != ZERO);
  assign neg  = cnt_q[CNT_W-1];

  always_comb begin
    sym_d = ctrl_code(s1_q.ctrl);
    cnt_d = ZERO;
    if (s1_q.de) begin
      if ((cnt_q == ZERO) || (s1_q.n1 == 4'd4)) begin
        sym_d = {~qm8, qm8, qm8 ? qm : ~qm};
        cnt_d = qm8 ? (cnt_q + diff) : (cnt_q - diff);
      end else if ((pos && (s1_q.n1 > 4'd4)) ||
                   (neg && (s1_q.n1 < 4'd4))) begin
        sym_d = {1'b1, qm8, ~qm};
        cnt_d = cnt_q + (qm8 ? TWO : ZERO) - diff;
      end else begin
        sym_d = {1'b0, qm8, qm};
        cnt_d = cnt_q - (qm8 ? ZERO : TWO) + diff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sym_q <= ctrl_code(RESET_CTRL);
      cnt_q <= ZERO;
    end else begin
      sym_q <= sym_d;
      cnt_q <= cnt_d;
    end
  end

  assign sym_o = sym_q;

`ifdef TMDS_DISPARITY_MON_EN
  assign cnt_o = cnt_q;
`endif

endmodule

// File: rtl/tmds_encoder_rgb.sv
// Three-channel DVI TMDS encoder, 2-cycle latency, sync carried on blue.
// TMDS_DISPARITY_MON_EN adds disp_r/g/b and sticky disp_err outputs.
module tmds_encoder_rgb
  import video_pkg::*;
#(
  parameter int         CNT_W      = 5,
  parameter logic [1:0] RESET_CTRL = 2'b00
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [7:0]            rgb_r,
  input  logic [7:0]            rgb_g,
  input  logic [7:0]            rgb_b,
  input  logic                  de,
  input  logic                  hsync,
  input  logic                  vsync,
  output logic [TMDS_SYM_W-1:0] tmds_r,
  output logic [TMDS_SYM_W-1:0] tmds_g,
  output logic [TMDS_SYM_W-1:0] tmds_b
`ifdef TMDS_DISPARITY_MON_EN
  ,
  output logic signed [CNT_W-1:0] disp_r,
  output logic signed [CNT_W-1:0] disp_g,
  output logic signed [CNT_W-1:0] disp_b,
  output logic                    disp_err
`endif
);

  logic [1:0] ctrl_b;

  assign ctrl_b = {vsync, hsync};

  tmds_channel_enc #(
    .CNT_W      (CNT_W),
    .RESET_CTRL (RESET_CTRL)
  ) u_ch2 (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (rgb_r),
    .de_i   (de),
    .ctrl_i (2'b00),
`ifdef TMDS_DISPARITY_MON_EN
    .cnt_o  (disp_r),
`endif
    .sym_o  (tmds_r)
  );

  tmds_channel_enc #(
    .CNT_W      (CNT_W),
    .RESET_CTRL (RESET_CTRL)
  ) u_ch1 (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (rgb_g),
    .de_i   (de),
    .ctrl_i (2'b00),
`ifdef TMDS_DISPARITY_MON_EN
    .cnt_o  (disp_g),
`endif
    .sym_o  (tmds_g)
  );

  tmds_channel_enc #(
    .CNT_W      (CNT_W),
    .RESET_CTRL (RESET_CTRL)
  ) u_ch0 (
    .clk    (clk),
    .rst_n  (rst_n),
    .d_i    (rgb_b),
    .de_i   (de),
    .ctrl_i (ctrl_b),
`ifdef TMDS_DISPARITY_MON_EN
    .cnt_o  (disp_b),
`endif
    .sym_o  (tmds_b)
  );

`ifdef TMDS_DISPARITY_MON_EN
  localparam logic signed [CNT_W-1:0] LIM  = CNT_W'(10);
  localparam logic signed [CNT_W-1:0] NLIM = -LIM;

  logic disp_err_d, disp_err_q;

  always_comb begin
    disp_err_d = disp_err_q;
    if ((disp_r > LIM) || (disp_r < NLIM) ||
        (disp_g > LIM) || (disp_g < NLIM) ||
        (disp_b > LIM) || (disp_b < NLIM)) begin
      disp_err_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_err_q <= 1'b0;
    end else begin
      disp_err_q <= disp_err_d;
    end
  end

  assign disp_err = disp_err_q;
`endif

endmodule

// File: tb/tb_tmds_encoder_rgb.sv
// Scoreboard bench for tmds_encoder_rgb: directed vectors plus a
// behavioural DVI reference for random DE runs.
module tb_tmds_encoder_rgb;

  logic       clk = 1'b0;
  logic       rst_n;
  logic [7:0] rgb_r, rgb_g, rgb_b;
  logic       de, hsync, vsync;
  logic [9:0] tmds_r, tmds_g, tmds_b;
`ifdef TMDS_DISPARITY_MON_EN
  logic signed [4:0] disp_r, disp_g, disp_b;
  logic              disp_err;
`endif

  tmds_encoder_rgb dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .rgb_r    (rgb_r),
    .rgb_g    (rgb_g),
    .rgb_b    (rgb_b),
    .de       (de),
    .hsync    (hsync),
    .vsync    (vsync),
`ifdef TMDS_DISPARITY_MON_EN
    .disp_r   (disp_r),
    .disp_g   (disp_g),
    .disp_b   (disp_b),
    .disp_err (disp_err),
`endif
    .tmds_r   (tmds_r),
    .tmds_g   (tmds_g),
    .tmds_b   (tmds_b)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int          due;
    logic [9:0]  r, g, b;
    logic        dat;
    logic [7:0]  dr, dg, db;
    logic [63:0] tag;
  } exp_t;

  exp_t q[$];
  exp_t e;
  int   checks = 0;
  int   errors = 0;
  int   mc[3];

  task automatic chk(input logic [63:0] nm,
                     input logic [9:0] act,
                     input logic [9:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      errors++;
      $display("FAIL %s: got %h want %h (cycle %0d)",
               nm, act, exp_v, cyc);
    end
  endtask

  function automatic logic [7:0] decode(input logic [9:0] s);
    logic [7:0] w, d;
    w    = s[9] ? ~s[7:0] : s[7:0];
    d[0] = w[0];
    for (int i = 1; i < 8; i++)
      d[i] = s[8] ? (w[i] ^ w[i-1]) : ~(w[i] ^ w[i-1]);
    return d;
  endfunction

  function automatic void model(input logic [7:0] d,
                                input logic dv,
                                input logic [1:0] c,
                                input int cin,
                                output logic [9:0] s,
                                output int cout);
    logic [8:0] qm;
    int n1, n1q, n0q;
    if (!dv) begin
      case (c)
        2'b00:   s = 10'b1101010100;
        2'b01:   s = 10'b0010101011;
        2'b10:   s = 10'b0101010100;
        default: s = 10'b1010101011;
      endcase
      cout = 0;
      return;
    end
    n1 = $countones(d);
    qm[0] = d[0];
    if (n1 > 4 || (n1 == 4 && d[0] == 1'b0)) begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ~^ d[i];
      qm[8] = 1'b0;
    end else begin
      for (int i = 1; i < 8; i++) qm[i] = qm[i-1] ^ d[i];
      qm[8] = 1'b1;
    end
    n1q = $countones(qm[7:0]);
    n0q = 8 - n1q;
    if (cin == 0 || n1q == n0q) begin
      s = {~qm[8], qm[8], qm[8] ? qm[7:0] : ~qm[7:0]};
      cout = qm[8] ? cin + n1q - n0q : cin + n0q - n1q;
    end else if ((cin > 0 && n1q > n0q) ||
                 (cin < 0 && n0q > n1q)) begin
      s = {1'b1, qm[8], ~qm[7:0]};
      cout = cin + 2 * int'(qm[8]) + n0q - n1q;
    end else begin
      s = {1'b0, qm[8], qm[7:0]};
      cout = cin - (qm[8] ? 0 : 2) + n1q - n0q;
    end
  endfunction

  // use_exp selects hand-computed symbols over the reference model.
  task automatic drive(input logic [7:0] r, g, b,
                       input logic dv, hs, vs,
                       input logic use_exp,
                       input logic [9:0] er, eg, eb,
                       input logic [63:0] tag);
    exp_t x;
    logic [9:0] sr, sg, sb;
    int c;
    @(posedge clk);
    #1;
    rgb_r = r; rgb_g = g; rgb_b = b;
    de = dv; hsync = hs; vsync = vs;
    model(r, dv, 2'b00, mc[2], sr, c); mc[2] = c;
    model(g, dv, 2'b00, mc[1], sg, c); mc[1] = c;
    model(b, dv, {vs, hs}, mc[0], sb, c); mc[0] = c;
    x.due = cyc + 2;
    x.r   = use_exp ? er : sr;
    x.g   = use_exp ? eg : sg;
    x.b   = use_exp ? eb : sb;
    x.dat = dv;
    x.dr = r; x.dg = g; x.db = b;
    x.tag = tag;
    q.push_back(x);
  endtask

  task automatic blank(input int n);
    for (int i = 0; i < n; i++)
      drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b0,
            1'b1, 10'h354, 10'h354, 10'h354, "blank");
  endtask

  always @(negedge clk) begin
    if (q.size() != 0 && q[0].due < cyc) begin
      checks++;
      errors++;
      $display("FAIL stale: entry %s due %0d, now %0d",
               q[0].tag, q[0].due, cyc);
      void'(q.pop_front());
    end else if (q.size() != 0 && q[0].due == cyc) begin
      e = q.pop_front();
      chk({e.tag[39:0], "_r"}, tmds_r, e.r);
      chk({e.tag[39:0], "_g"}, tmds_g, e.g);
      chk({e.tag[39:0], "_b"}, tmds_b, e.b);
      if (e.dat) begin
        chk("dec_r", {2'b00, decode(tmds_r)}, {2'b00, e.dr});
        chk("dec_g", {2'b00, decode(tmds_g)}, {2'b00, e.dg});
        chk("dec_b", {2'b00, decode(tmds_b)}, {2'b00, e.db});
      end
    end
  end

  initial begin
    logic dv;
    int   run, n;
    rst_n = 1'b0;
    rgb_r = '0; rgb_g = '0; rgb_b = '0;
    de = 1'b0; hsync = 1'b0; vsync = 1'b0;
    mc[0] = 0; mc[1] = 0; mc[2] = 0;
    repeat (3) @(posedge clk);
    #2;
    chk("rst_r", tmds_r, 10'h354);
    chk("rst_g", tmds_g, 10'h354);
    chk("rst_b", tmds_b, 10'h354);
    @(negedge clk);
    rst_n = 1'b1;
    blank(3);

    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b0,
          1'b1, 10'h354, 10'h354, 10'h0AB, "hsync");
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1'b1,
          1'b1, 10'h354, 10'h354, 10'h2AB, "hvsync");
    drive(8'h00, 8'h00, 8'h00, 1'b0, 1'b0, 1'b1,
          1'b1, 10'h354, 10'h354, 10'h154, "vsync");
    blank(2);

    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0,
          1'b1, 10'h100, 10'h100, 10'h100, "dc0");
    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0,
          1'b1, 10'h3FF, 10'h3FF, 10'h3FF, "dc1");
    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0,
          1'b1, 10'h100, 10'h100, 10'h100, "dc2");
    blank(2);

    for (int k = 0; k < 2; k++) begin
      drive(8'h00, 8'hFF, 8'h00, 1'b1, 1'b0, 1'b0,
            1'b1, 10'h100, 10'h200, 10'h100, "pulse");
      blank(2);
    end

    dv = 1'b0;
    n  = 0;
    while (n < 10000) begin
      run = $urandom_range(1, 30);
      dv  = ~dv;
      for (int j = 0; j < run && n < 10000; j++) begin
        drive(8'($urandom), 8'($urandom), 8'($urandom),
              dv, 1'($urandom), 1'($urandom),
              1'b0, '0, '0, '0, "rand");
        n++;
      end
    end
    blank(2);

    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0,
          1'b1, 10'h100, 10'h100, 10'h100, "pre0");
    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0,
          1'b1, 10'h3FF, 10'h3FF, 10'h3FF, "pre1");
    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0,
          1'b1, 10'h100, 10'h100, 10'h100, "pre2");
    @(negedge clk);
    #1;
    rst_n = 1'b0;
    de = 1'b0;
    q.delete();
    mc[0] = 0; mc[1] = 0; mc[2] = 0;
    #1;
    chk("arst_r", tmds_r, 10'h354);
    chk("arst_g", tmds_g, 10'h354);
    chk("arst_b", tmds_b, 10'h354);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    drive(8'h00, 8'h00, 8'h00, 1'b1, 1'b0, 1'b0,
          1'b1, 10'h100, 10'h100, 10'h100, "post");
    blank(3);

    for (int i = 0; i < 10 && q.size() != 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain: %0d entries left, want 0", q.size());
    end
`ifdef TMDS_DISPARITY_MON_EN
    chk("disp_err", {9'b0, disp_err}, 10'h000);
`endif
    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule

// File: doc/tmds_encoder_rgb.md
Name: tmds_encoder_rgb

Overview:
- Sits directly downstream of the GPU output multiplexer and feeds the 10:1 serializers of the DVI transmitter.
- Takes the selected RGB888 pixel plus DE/HSYNC/VSYNC and produces three DVI 1.0 TMDS 10-bit symbols per pixel clock.
- Pipelined: 2 clocks of latency; sync/DE are delayed to match.
- Running DC-balance disparity is held per channel.

Parameters:
- CNT_W, 5, width of signed running-disparity counter; legal range -16..+15; minimum 5.
- RESET_CTRL, 2'b00, control symbol emitted on all three channels out of reset.

Ports:
- clk  input  1  pixel clock
- rst_n  input  1  asynchronous active-low reset
- rgb_r  input  8  red pixel from gpu mux
- rgb_g  input  8  green pixel
- rgb_b  input  8  blue pixel
- de  input  1  data enable (active video)
- hsync  input  1  horizontal sync, polarity passed through unchanged
- vsync  input  1  vertical sync, polarity passed through unchanged
- tmds_r  output  10  channel 2 symbol, LSB transmitted first
- tmds_g  output  10  channel 1 symbol
- tmds_b  output  10  channel 0 symbol

Behaviour:
- One clock (clk); reset is asynchronous, active-low (rst_n).
- Reset: all pipeline registers cleared. tmds_r/g/b = control code for RESET_CTRL (default 10'h354). All disparity counters = 0.
- Stage 1 (clk edge 1):
  - Register pixel, de and ctrl. Blue ctrl = {vsync,hsync}; green and red ctrl = 2'b00.
  - Compute N1(D) and q_m[8:0]. Use the XNOR chain if N1>4, or N1==4 with D[0]==0; otherwise the XOR chain.
  - q_m[8] = 1 for XOR, 0 for XNOR.
  - Register q_m and N1(q_m[7:0]).
- Stage 2 (clk edge 2): symbol out and counter update, per DVI 1.0 §3.3.3.
  - If de_d==0:
    - Output the control code: 00→10'h354, 01→10'h0AB, 10→10'h154, 11→10'h2AB.
    - cnt forced to 0.
  - Else if cnt==0 or N1==N0:
    - out = {~q_m[8], q_m[8], q_m[8] ? q_m[7:0] : ~q_m[7:0]}.
    - cnt += q_m[8] ? (N1-N0) : (N0-N1).
  - Else if (cnt>0 and N1>N0) or (cnt<0 and N0>N1):
    - out = {1, q_m[8], ~q_m[7:0]}.
    - cnt += 2*q_m[8] + (N0-N1).
  - Else:
    - out = {0, q_m[8], q_m[7:0]}.
    - cnt += -2*(~q_m[8]) + (N1-N0).
- Latency: input at edge k appears on tmds_* after edge k+2. Throughput: one pixel per clock, no stall.
- Arithmetic:
  - N0 = 8 - N1.
  - All cnt math is signed CNT_W bits.
  - The |cnt| ≤ 10 invariant holds by construction; no saturation logic.
- DE transitions:
  - The first active pixel after blanking always starts with cnt=0.
  - The DE falling edge switches to a control symbol on the same aligned cycle.
- Reset mid-line: outputs return to the reset control code asynchronously. The first pixel after release uses cnt=0.

Optional Feature:
- Macro: TMDS_DISPARITY_MON_EN.
- When defined, add output ports:
  - disp_r, disp_g, disp_b (CNT_W, signed current cnt per channel).
  - disp_err (1, sticky). Sets when any |cnt| > 10; cleared only by rst_n.
- When undefined: these ports and all associated logic are absent. Encoding is identical in both builds.

Decomposition:
- video_pkg holds:
  - TMDS control-code localparams (CTRL_00..CTRL_11).
  - TMDS_SYM_W=10.
  - The reset-code selection function.
- One sub-module, tmds_channel_enc, contains the two-stage pipeline and disparity counter for one channel. It is instantiated three times.
- The top level does only the ctrl mapping and instantiation.

Test Plan:
- Reset: hold rst_n=0, then release with de=0, hsync=vsync=0 → tmds_r/g/b = 10'h354 during reset and after release.
- Blanking sync: de=0, hsync=1, vsync=0 → tmds_b = 10'h0AB two clocks later; tmds_g = tmds_r = 10'h354. With vsync=1, hsync=1 → tmds_b = 10'h2AB.
- DC balance: de=1, rgb_b=8'h00 for 3 pixels starting from blanking → tmds_b = 10'h100, 10'h3FF, 10'h100; monitor cnt = -8, 2, -6.
- Latency/DE edge: 1-pixel DE pulse with rgb_g=8'hFF between blanking → exactly one data symbol on tmds_g, at edge+2, flanked by 10'h354. cnt is 0 afterwards.
- Reference model: 10,000 random pixels with random DE runs, compared against a behavioural DVI encoder → bit-exact on all channels. Decoding each symbol returns the original byte. disp_err stays 0.
- Async reset mid-line: assert rst_n during active video with cnt≠0 → immediate 10'h354 on all channels. The next active pixel encodes as if from cnt=0.
